// File: rtl/digit_scan_capture_if.sv
// Bundle for the multiplexed seven-segment bus and the capture monitor's results.
// The display driver side uses master; the capture monitor uses slave.
interface digit_scan_capture_if #(
  parameter int SEG_W = 7
);
  logic               d0;
  logic               d1;
  logic               d2;
  logic               d3;
  logic [SEG_W-1:0]   seg_in;
  logic [4*SEG_W-1:0] digits;
  logic [3:0]         seen;
  logic [1:0]         active_idx;
  logic               frame_done;
  logic               sel_err;
  logic               scan_timeout;

  modport master (
    output d0, d1, d2, d3, seg_in,
    input  digits, seen, active_idx, frame_done, sel_err, scan_timeout
  );

  modport slave (
    input  d0, d1, d2, d3, seg_in,
    output digits, seen, active_idx, frame_done, sel_err, scan_timeout
  );
endinterface

// File: rtl/digit_scan_capture.sv
// Rebuilds the four digit patterns from a scanned seven-segment bus and flags bad strobes and stalls.
// Optional macro SEG_ACTIVE_LOW_EN: invert seg_in before storage for common-anode panels.
module digit_scan_capture #(
  parameter int SEG_W         = 7,
  parameter int STABLE_CYCLES = 2,
  parameter int TIMEOUT       = 255
) (
  input logic                 clk,
  input logic                 reset,
  digit_scan_capture_if.slave bus
);

  localparam logic [3:0]  STABLE_C  = 4'(STABLE_CYCLES);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [3:0]       pat;
  logic             pat_valid;
  logic             pat_blank;
  logic             pat_illegal;
  logic [1:0]       pat_idx;
  logic [SEG_W-1:0] seg_store;

  logic [3:0]         prev_q, prev_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [4*SEG_W-1:0] digits_q, digits_d;
  logic [3:0]         seen_q, seen_d;
  logic [1:0]         idx_q, idx_d;
  logic               frame_done_q, frame_done_d;
  logic               sel_err_q, sel_err_d;
  logic               scan_timeout_q, scan_timeout_d;
  logic               capture;
  logic [3:0]         seen_next;

  assign pat = {bus.d3, bus.d2, bus.d1, bus.d0};

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_store = ~bus.seg_in;
`else
  assign seg_store = bus.seg_in;
`endif

  always_comb begin
    pat_valid = 1'b1;
    pat_idx   = 2'd0;
    case (pat)
      4'b1110: pat_idx = 2'd0;
      4'b1101: pat_idx = 2'd1;
      4'b1011: pat_idx = 2'd2;
      4'b0111: pat_idx = 2'd3;
      default: pat_valid = 1'b0;
    endcase
    pat_blank   = (pat == 4'b1111);
    pat_illegal = !pat_valid && !pat_blank;
  end

  always_comb begin
    prev_d         = pat;
    cnt_d          = 4'd0;
    tmo_d          = tmo_q;
    digits_d       = digits_q;
    seen_d         = seen_q;
    idx_d          = idx_q;
    frame_done_d   = 1'b0;
    sel_err_d      = 1'b0;
    scan_timeout_d = scan_timeout_q;
    seen_next      = seen_q;

    if (pat_valid) begin
      if (pat == prev_q)
        cnt_d = (cnt_q >= STABLE_C) ? STABLE_C : cnt_q + 4'd1;
      else
        cnt_d = 4'd1;
    end

    // A saturated counter on the same pattern must not capture again in this window.
    capture   = pat_valid && (cnt_d == STABLE_C) &&
                ((pat != prev_q) || (cnt_q != STABLE_C));
    sel_err_d = pat_illegal && (pat != prev_q);

    if (capture) begin
      for (int n = 0; n < 4; n++) begin
        if (pat_idx == 2'(n))
          digits_d[n*SEG_W +: SEG_W] = seg_store;
      end
      idx_d          = pat_idx;
      tmo_d          = 16'd0;
      scan_timeout_d = 1'b0;
      seen_next      = seen_q | (4'b0001 << pat_idx);
      if (seen_next == 4'b1111) begin
        seen_d       = 4'b0000;
        frame_done_d = 1'b1;
      end else begin
        seen_d = seen_next;
      end
    end else if (tmo_q != TIMEOUT_C) begin
      tmo_d = tmo_q + 16'd1;
      if (tmo_d == TIMEOUT_C) begin
        scan_timeout_d = 1'b1;
        seen_d         = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q         <= 4'd0;
      cnt_q          <= 4'd0;
      tmo_q          <= 16'd0;
      digits_q       <= '0;
      seen_q         <= 4'd0;
      idx_q          <= 2'd0;
      frame_done_q   <= 1'b0;
      sel_err_q      <= 1'b0;
      scan_timeout_q <= 1'b0;
    end else begin
      prev_q         <= prev_d;
      cnt_q          <= cnt_d;
      tmo_q          <= tmo_d;
      digits_q       <= digits_d;
      seen_q         <= seen_d;
      idx_q          <= idx_d;
      frame_done_q   <= frame_done_d;
      sel_err_q      <= sel_err_d;
      scan_timeout_q <= scan_timeout_d;
    end
  end

  assign bus.digits       = digits_q;
  assign bus.seen         = seen_q;
  assign bus.active_idx   = idx_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.sel_err      = sel_err_q;
  assign bus.scan_timeout = scan_timeout_q;

endmodule

// File: tb/tb_digit_scan_capture.sv
// Table-driven, scoreboarded bench for digit_scan_capture (STABLE_CYCLES = 2, TIMEOUT = 8).
// Expected digit values follow SEG_ACTIVE_LOW_EN when that macro is defined.
module tb_digit_scan_capture;

  localparam int SEG_W = 7;

  typedef struct {
    logic        rst;
    logic [3:0]  p;
    logic [6:0]  seg;
    logic [3:0]  seen;
    logic [1:0]  idx;
    logic        fd;
    logic        se;
    logic        to;
    logic        chk_dig;
    logic [27:0] dig;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  digit_scan_capture_if #(.SEG_W(SEG_W)) bus_if ();

  digit_scan_capture #(
    .SEG_W        (SEG_W),
    .STABLE_CYCLES(2),
    .TIMEOUT      (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] cv(input logic [6:0] x);
`ifdef SEG_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  function automatic logic [27:0] pack4(input logic [6:0] a3, input logic [6:0] a2,
                                        input logic [6:0] a1, input logic [6:0] a0);
    return {cv(a3), cv(a2), cv(a1), cv(a0)};
  endfunction

  function automatic void addN(input int n, input logic rst, input logic [3:0] p,
                               input logic [6:0] seg, input logic [3:0] seen,
                               input logic [1:0] idx, input logic fd, input logic se,
                               input logic to);
    vec_t v;
    v.rst = rst; v.p = p; v.seg = seg; v.seen = seen; v.idx = idx;
    v.fd = fd; v.se = se; v.to = to; v.chk_dig = 1'b0; v.dig = '0;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  function automatic void expDig(input logic [27:0] d);
    tbl[tbl.size()-1].chk_dig = 1'b1;
    tbl[tbl.size()-1].dig     = d;
  endfunction

  task automatic cmp(input string name, input int row, input logic [27:0] got,
                     input logic [27:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s row %0d: got %0h expected %0h", name, row, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset         = v.rst;
    bus_if.d0     = v.p[0];
    bus_if.d1     = v.p[1];
    bus_if.d2     = v.p[2];
    bus_if.d3     = v.p[3];
    bus_if.seg_in = v.seg;
    sb.push_back(v);
  endtask

  task automatic checkOutput(input int row);
    vec_t e;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", row, 28'd1, 28'd0);
    end else begin
      e = sb.pop_front();
      cmp("seen",         row, 28'(bus_if.seen),         28'(e.seen));
      cmp("active_idx",   row, 28'(bus_if.active_idx),   28'(e.idx));
      cmp("frame_done",   row, 28'(bus_if.frame_done),   28'(e.fd));
      cmp("sel_err",      row, 28'(bus_if.sel_err),      28'(e.se));
      cmp("scan_timeout", row, 28'(bus_if.scan_timeout), 28'(e.to));
      if (e.chk_dig) cmp("digits", row, bus_if.digits, e.dig);
    end
  endtask

  initial begin
    int n;

    // Reset, then a full scan with three edges per digit.
    addN(1, 1, 4'b1111, 7'h00, 4'b0000, 2'd0, 0, 0, 0);
    addN(1, 0, 4'b1110, 7'h3F, 4'b0000, 2'd0, 0, 0, 0);
    addN(2, 0, 4'b1110, 7'h3F, 4'b0001, 2'd0, 0, 0, 0);
    addN(1, 0, 4'b1101, 7'h06, 4'b0001, 2'd0, 0, 0, 0);
    addN(2, 0, 4'b1101, 7'h06, 4'b0011, 2'd1, 0, 0, 0);
    addN(1, 0, 4'b1011, 7'h5B, 4'b0011, 2'd1, 0, 0, 0);
    addN(2, 0, 4'b1011, 7'h5B, 4'b0111, 2'd2, 0, 0, 0);
    addN(1, 0, 4'b0111, 7'h4F, 4'b0111, 2'd2, 0, 0, 0);
    addN(1, 0, 4'b0111, 7'h4F, 4'b0000, 2'd3, 1, 0, 0);
    addN(1, 0, 4'b0111, 7'h4F, 4'b0000, 2'd3, 0, 0, 0);
    expDig(pack4(7'h4F, 7'h5B, 7'h06, 7'h3F));
    // A one-edge strobe is too short to capture.
    addN(1, 0, 4'b1110, 7'h11, 4'b0000, 2'd3, 0, 0, 0);
    addN(1, 0, 4'b1101, 7'h22, 4'b0000, 2'd3, 0, 0, 0);
    addN(2, 0, 4'b1101, 7'h22, 4'b0010, 2'd1, 0, 0, 0);
    expDig(pack4(7'h4F, 7'h5B, 7'h22, 7'h3F));
    // Held illegal strobe gives a single error pulse and no capture.
    addN(1, 0, 4'b1100, 7'h7F, 4'b0010, 2'd1, 0, 1, 0);
    addN(3, 0, 4'b1100, 7'h7F, 4'b0010, 2'd1, 0, 0, 0);
    addN(1, 0, 4'b1110, 7'h05, 4'b0010, 2'd1, 0, 0, 0);
    addN(1, 0, 4'b1110, 7'h05, 4'b0011, 2'd0, 0, 0, 0);
    expDig(pack4(7'h4F, 7'h5B, 7'h22, 7'h05));
    // Mid-frame reset, then a fresh scan; digit 2 carries the active-low sample 7'h40.
    addN(1, 1, 4'b1110, 7'h3F, 4'b0000, 2'd0, 0, 0, 0);
    expDig(28'd0);
    addN(1, 0, 4'b1110, 7'h3F, 4'b0000, 2'd0, 0, 0, 0);
    addN(1, 0, 4'b1110, 7'h3F, 4'b0001, 2'd0, 0, 0, 0);
    addN(1, 0, 4'b1101, 7'h06, 4'b0001, 2'd0, 0, 0, 0);
    addN(1, 0, 4'b1101, 7'h06, 4'b0011, 2'd1, 0, 0, 0);
    addN(1, 0, 4'b1011, 7'h40, 4'b0011, 2'd1, 0, 0, 0);
    addN(1, 0, 4'b1011, 7'h40, 4'b0111, 2'd2, 0, 0, 0);
    addN(1, 0, 4'b0111, 7'h4F, 4'b0111, 2'd2, 0, 0, 0);
    addN(1, 0, 4'b0111, 7'h4F, 4'b0000, 2'd3, 1, 0, 0);
    expDig(pack4(7'h4F, 7'h40, 7'h06, 7'h3F));
    // Capture digit 0 then idle blank: timeout at the 8th edge clears seen.
    addN(1, 0, 4'b1110, 7'h0A, 4'b0000, 2'd3, 0, 0, 0);
    addN(1, 0, 4'b1110, 7'h0A, 4'b0001, 2'd0, 0, 0, 0);
    addN(7, 0, 4'b1111, 7'h00, 4'b0001, 2'd0, 0, 0, 0);
    addN(2, 0, 4'b1111, 7'h00, 4'b0000, 2'd0, 0, 0, 1);
    addN(1, 0, 4'b0111, 7'h4F, 4'b0000, 2'd0, 0, 0, 1);
    addN(1, 0, 4'b0111, 7'h4F, 4'b1000, 2'd3, 0, 0, 0);
    expDig(pack4(7'h4F, 7'h40, 7'h06, 7'h0A));
    // Frame-completing capture lands on the would-be timeout edge: capture wins.
    addN(1, 0, 4'b1110, 7'h01, 4'b1000, 2'd3, 0, 0, 0);
    addN(1, 0, 4'b1110, 7'h01, 4'b1001, 2'd0, 0, 0, 0);
    addN(1, 0, 4'b1101, 7'h02, 4'b1001, 2'd0, 0, 0, 0);
    addN(1, 0, 4'b1101, 7'h02, 4'b1011, 2'd1, 0, 0, 0);
    addN(6, 0, 4'b1111, 7'h00, 4'b1011, 2'd1, 0, 0, 0);
    addN(1, 0, 4'b1011, 7'h04, 4'b1011, 2'd1, 0, 0, 0);
    addN(1, 0, 4'b1011, 7'h04, 4'b0000, 2'd2, 1, 0, 0);
    addN(1, 0, 4'b1111, 7'h00, 4'b0000, 2'd2, 0, 0, 0);
    expDig(pack4(7'h4F, 7'h04, 7'h02, 7'h01));

    reset         = 1'b1;
    bus_if.d0     = 1'b1;
    bus_if.d1     = 1'b1;
    bus_if.d2     = 1'b1;
    bus_if.d3     = 1'b1;
    bus_if.seg_in = '0;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      @(posedge clk);
      #1;
      checkOutput(i);
    end

    // Timeout counter sits at 1 here; holding blank must stall after exactly 7 more edges.
    n = 0;
    while (!bus_if.scan_timeout && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    cmp("timeout_edges",      0, 28'(n),                   28'd7);
    cmp("timeout_level",      0, 28'(bus_if.scan_timeout), 28'd1);
    cmp("timeout_seen_clear", 0, 28'(bus_if.seen),         28'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
